// File: rtl/move_if.sv
// move_if: start/done handshake, candidate box geometry and grid map between the player FSM and move_validator.
interface move_if #(parameter int GRID_N = 8);
   logic                         start;
   logic                         done;
   logic                         move_is_valid;
   logic [0:2*GRID_N*GRID_N-1]   grid_color;
   logic [9:0]                   x_pos;
   logic [9:0]                   y_pos;
   logic [9:0]                   width;
   logic [9:0]                   height;
   logic [1:0]                   l_r;
   logic [1:0]                   u_d;
   modport master (
      output start, grid_color, x_pos, y_pos, width, height, l_r, u_d,
      input  done, move_is_valid
   );
   modport slave (
      input  start, grid_color, x_pos, y_pos, width, height, l_r, u_d,
      output done, move_is_valid
   );
endinterface

// File: rtl/move_validator.sv
// move_validator: answers a start/done request by checking the four corners of the stepped player box against the floor grid.
module move_validator #(
   parameter int GRID_X0 = 80,
   parameter int GRID_Y0 = 0,
   parameter int CELL_W  = 60,
   parameter int CELL_H  = 60,
   parameter int GRID_N  = 8
) (
   input  logic   clk,
   input  logic   rst,
   move_if.slave  bus
);
   localparam int KW = $clog2(GRID_N);
   localparam logic [KW-1:0] LAST = KW'(GRID_N - 1);
   typedef enum logic [2:0] {IDLE, LOAD, SCAN, LOOKUP, DONE} state_t;
   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d, col_q, col_d, row_q, row_d;
   logic [1:0]    corner_q, corner_d;
   logic [10:0]   nx_q, nx_d, ny_q, ny_d, rx_q, rx_d, by_q, by_d;
   logic          valid_q, valid_d, done_q, done_d, miv_q, miv_d;
   logic [10:0]   nx, ny, px, py;
   logic          col_inc, row_inc, in_grid;
   logic [1:0]    colour;
   assign bus.done          = done_q;
   assign bus.move_is_valid = miv_q;
   always_comb begin
      nx = {1'b0, bus.x_pos} + (bus.l_r == 2'd1 ? 11'd1 : 11'd0) - (bus.l_r == 2'd2 ? 11'd1 : 11'd0);
      ny = {1'b0, bus.y_pos} + (bus.u_d == 2'd1 ? 11'd1 : 11'd0) - (bus.u_d == 2'd2 ? 11'd1 : 11'd0);
      px = corner_q[0] ? rx_q : nx_q;
      py = corner_q[1] ? by_q : ny_q;
      col_inc = int'(px) >= GRID_X0 + (int'(k_q) + 1) * CELL_W;
      row_inc = int'(py) >= GRID_Y0 + (int'(k_q) + 1) * CELL_H;
      in_grid = int'(px) >= GRID_X0 && int'(px) < GRID_X0 + GRID_N * CELL_W &&
                int'(py) >= GRID_Y0 && int'(py) < GRID_Y0 + GRID_N * CELL_H;
      // {row,col} equals row*GRID_N+col because GRID_N is a power of two
      colour = {bus.grid_color[{row_q, col_q, 1'b0}], bus.grid_color[{row_q, col_q, 1'b1}]};
   end
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      col_d    = col_q;
      row_d    = row_q;
      corner_d = corner_q;
      nx_d     = nx_q;
      ny_d     = ny_q;
      rx_d     = rx_q;
      by_d     = by_q;
      valid_d  = valid_q;
      done_d   = done_q;
      miv_d    = miv_q;
      case (state_q)
         IDLE: begin
            done_d  = 1'b0;
            state_d = bus.start ? LOAD : IDLE;
         end
         LOAD: begin
            nx_d     = nx;
            ny_d     = ny;
            rx_d     = nx + {1'b0, bus.width} - 11'd1;
            by_d     = ny + {1'b0, bus.height} - 11'd1;
            valid_d  = 1'b1;
            k_d      = '0;
            col_d    = '0;
            row_d    = '0;
            corner_d = '0;
            state_d  = SCAN;
         end
         SCAN: begin
            col_d   = col_q + KW'(col_inc && col_q != LAST);
            row_d   = row_q + KW'(row_inc && row_q != LAST);
            k_d     = k_q == LAST ? '0 : k_q + KW'(1);
            state_d = k_q == LAST ? LOOKUP : SCAN;
         end
         LOOKUP: begin
            valid_d  = valid_q && in_grid && colour == 2'b00;
            col_d    = '0;
            row_d    = '0;
            k_d      = '0;
            corner_d = corner_q + 2'd1;
            state_d  = corner_q == 2'd3 ? DONE : SCAN;
         end
         DONE: begin
            done_d  = bus.start;
            miv_d   = valid_q;
            state_d = bus.start ? DONE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         col_q    <= '0;
         row_q    <= '0;
         corner_q <= '0;
         nx_q     <= '0;
         ny_q     <= '0;
         rx_q     <= '0;
         by_q     <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         miv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         col_q    <= col_d;
         row_q    <= row_d;
         corner_q <= corner_d;
         nx_q     <= nx_d;
         ny_q     <= ny_d;
         rx_q     <= rx_d;
         by_q     <= by_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         miv_q    <= miv_d;
      end
   end
endmodule
